// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer (slave) and the datapath/memory side (master).
// Perf counter signals exist only when MULTICYCLE_PERF_EN is defined.
interface multicycle_sequencer_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        negative;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        adr_src;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  imm_src;
  logic [1:0]  aluop;
  logic        illegal;
  logic        bus_err;
  logic [3:0]  state;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  modport slave (
    input  opcode, funct3, zero, negative, mem_ready,
    output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
    output result_src, alu_src_a, alu_src_b, imm_src, aluop,
    output illegal, bus_err, state
`ifdef MULTICYCLE_PERF_EN
    , output cycle_cnt, output instret_cnt
`endif
  );

  modport master (
    output opcode, funct3, zero, negative, mem_ready,
    input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, imm_src, aluop,
    input  illegal, bus_err, state
`ifdef MULTICYCLE_PERF_EN
    , input cycle_cnt, input instret_cnt
`endif
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle fetch/decode/execute/mem/writeback control FSM sharing one memory port, with bounded
// mem_ready wait and illegal-opcode trap. Define MULTICYCLE_PERF_EN to add cycle/instret counters.
module multicycle_sequencer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  multicycle_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_ALUWB = 4'd7,
    S_EXECI = 4'd8, S_JAL = 4'd9, S_BRANCH = 4'd10, S_TRAP = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0] LIM = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_illegal, r_bus_err;
  logic             w_waiting, w_timeout, w_taken, w_set_illegal;
  logic             w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE))
                     && !bus.mem_ready;
  assign w_timeout = (WAIT_LIMIT > 0) && w_waiting && (r_wait_cnt == LIM);

  always_comb begin
    w_taken = 1'b0;
    case (bus.funct3)
      3'b000:  w_taken = bus.zero;
      3'b001:  w_taken = !bus.zero;
      3'b100:  w_taken = bus.negative;
      3'b101:  w_taken = !bus.negative;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.imm_src    = 2'b00;
    bus.aluop      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read     = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        w_pc_write     = bus.mem_ready;
        w_ir_write     = bus.mem_ready;
        if (w_timeout)          w_next = S_TRAP;
        else if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = 2'b10;
        case (bus.opcode)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1101111:             w_next = S_JAL;
          7'b1100011:             w_next = S_BRANCH;
          default: begin
            w_next        = S_TRAP;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = bus.opcode[5] ? 2'b01 : 2'b00;
        w_next        = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        w_mem_read  = 1'b1;
        if (w_timeout)          w_next = S_TRAP;
        else if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        w_reg_write    = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adr_src = 1'b1;
        w_mem_write = 1'b1;
        if (w_timeout)          w_next = S_TRAP;
        else if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.aluop     = 2'b10;
        w_next        = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.aluop     = 2'b10;
        w_next        = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the jump target already in ALUOut; ALU computes oldPC+4 for rd.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.imm_src   = 2'b11;
        w_pc_write    = 1'b1;
        w_next        = S_ALUWB;
      end
      S_BRANCH: begin
        bus.alu_src_a = 2'b10;
        bus.aluop     = 2'b01;
        w_pc_write    = w_taken;
        w_next        = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= ((w_next != r_state) || !w_waiting) ? '0 : r_wait_cnt + 1'b1;
      r_illegal  <= r_illegal | w_set_illegal;
      r_bus_err  <= r_bus_err | w_timeout;
    end
  end

  // Enables are gated by reset so nothing fires while the FSM sits in FETCH under reset.
  assign bus.pc_write  = w_pc_write  & i_reset;
  assign bus.ir_write  = w_ir_write  & i_reset;
  assign bus.mem_read  = w_mem_read  & i_reset;
  assign bus.mem_write = w_mem_write & i_reset;
  assign bus.reg_write = w_reg_write & i_reset;
  assign bus.illegal   = r_illegal;
  assign bus.bus_err   = r_bus_err;
  assign bus.state     = r_state;

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] r_cycle_cnt, r_instret_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != S_TRAP)
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if ((r_state != S_FETCH) && (w_next == S_FETCH))
        r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer; perf counter checks run when MULTICYCLE_PERF_EN is defined.
module tb_multicycle_sequencer;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  multicycle_sequencer_if sif();

  multicycle_sequencer #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enables();
    return {27'd0, sif.pc_write, sif.ir_write, sif.mem_read, sif.mem_write, sif.reg_write};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Leaves the bench at the first cycle of the BRANCH state's successor (FETCH).
  task automatic run_branch(input logic [2:0] f3, input logic z, input logic n, input logic exp_pc);
    sif.opcode = 7'b1100011; sif.funct3 = f3; sif.zero = z; sif.negative = n; sif.mem_ready = 1'b1;
    #1 check("br_fetch_state", 32'(sif.state), 32'd0);
    @(negedge clk);
    #1 check("br_decode_state", 32'(sif.state), 32'd1);
    @(negedge clk);
    #1 check("br_state", 32'(sif.state), 32'd10);
    check("br_aluop", 32'(sif.aluop), 32'd1);
    check("br_pc_write", 32'(sif.pc_write), 32'(exp_pc));
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    sif.opcode = 7'b0110011; sif.funct3 = 3'b000; sif.zero = 1'b0; sif.negative = 1'b0;
    sif.mem_ready = 1'b1;
    #2;
    check("rst_state", 32'(sif.state), 32'd0);
    check("rst_enables", enables(), 32'd0);
    check("rst_flags", {30'd0, sif.illegal, sif.bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // R-type: 0,1,6,7,0
    #1 check("r_fetch_state", 32'(sif.state), 32'd0);
    check("r_fetch_en", enables(), 32'b11100);
    check("r_fetch_sel", {26'd0, sif.alu_src_a, sif.alu_src_b, sif.result_src}, 32'b00_10_10);
    @(negedge clk);
    #1 check("r_decode_state", 32'(sif.state), 32'd1);
    check("r_decode_en", enables(), 32'd0);
    check("r_decode_sel", {26'd0, sif.alu_src_a, sif.alu_src_b, sif.imm_src}, 32'b01_01_10);
    @(negedge clk);
    #1 check("r_exec_state", 32'(sif.state), 32'd6);
    check("r_exec_aluop", 32'(sif.aluop), 32'd2);
    check("r_exec_en", enables(), 32'd0);
    @(negedge clk);
    #1 check("r_wb_state", 32'(sif.state), 32'd7);
    check("r_wb_en", enables(), 32'b00001);
    @(negedge clk);
    #1 check("r_back_fetch", 32'(sif.state), 32'd0);

    // Load with 3 wait cycles in MEMREAD
    sif.opcode = 7'b0000011;
    @(negedge clk);
    #1 check("ld_decode", 32'(sif.state), 32'd1);
    @(negedge clk);
    #1 check("ld_memadr", 32'(sif.state), 32'd2);
    check("ld_memadr_sel", {28'd0, sif.alu_src_a, sif.imm_src}, 32'b10_00);
    sif.mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sif.mem_ready = 1'b1;
      #1 check("ld_memread_state", 32'(sif.state), 32'd3);
      check("ld_memread_en", {30'd0, sif.adr_src, sif.mem_read}, 32'b11);
      @(negedge clk);
    end
    #1 check("ld_memwb_state", 32'(sif.state), 32'd4);
    check("ld_memwb_res", 32'(sif.result_src), 32'd1);
    check("ld_memwb_en", enables(), 32'b00001);
    @(negedge clk);

    // JAL: pc_write in JAL, then ALUWB
    sif.opcode = 7'b1101111;
    @(negedge clk);
    @(negedge clk);
    #1 check("jal_state", 32'(sif.state), 32'd9);
    check("jal_en", enables(), 32'b10000);
    check("jal_imm", 32'(sif.imm_src), 32'd3);
    @(negedge clk);
    #1 check("jal_wb_state", 32'(sif.state), 32'd7);
    @(negedge clk);

    // Branch decision table
    run_branch(3'b001, 1'b1, 1'b0, 1'b0);
    run_branch(3'b001, 1'b0, 1'b0, 1'b1);
    run_branch(3'b000, 1'b1, 1'b0, 1'b1);
    run_branch(3'b100, 1'b0, 1'b1, 1'b1);
    run_branch(3'b101, 1'b0, 1'b1, 1'b0);
    run_branch(3'b010, 1'b1, 1'b1, 1'b0);
    #1 check("br_return_fetch", 32'(sif.state), 32'd0);

    // Illegal opcode trap
    sif.opcode = 7'b1111111;
    @(negedge clk);
    #1 check("ill_decode", 32'(sif.state), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #1 check("ill_trap_state", 32'(sif.state), 32'd11);
      check("ill_trap_en", enables(), 32'd0);
      check("ill_flag", 32'(sif.illegal), 32'd1);
      @(negedge clk);
    end
    reset = 1'b0;
    #1 check("ill_rst_state", 32'(sif.state), 32'd0);
    check("ill_rst_flag", 32'(sif.illegal), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Timeout in FETCH: 15 cycles then TRAP
    sif.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1 check("to_fetch_hold", 32'(sif.state), 32'd0);
      @(negedge clk);
    end
    #1 check("to_trap_state", 32'(sif.state), 32'd11);
    check("to_bus_err", 32'(sif.bus_err), 32'd1);
    check("to_trap_en", enables(), 32'd0);

    // mem_ready on the 15th cycle wins
    do_reset();
    #1 check("to_rst_bus_err", 32'(sif.bus_err), 32'd0);
    for (int i = 0; i < 15; i++) begin
      if (i == 14) sif.mem_ready = 1'b1;
      #1 check("nto_fetch_hold", 32'(sif.state), 32'd0);
      @(negedge clk);
    end
    #1 check("nto_decode", 32'(sif.state), 32'd1);
    check("nto_bus_err", 32'(sif.bus_err), 32'd0);

    // Three R-types from reset, then store interrupted by reset
    sif.opcode = 7'b0110011;
    do_reset();
    repeat (12) @(negedge clk);
    #1 check("perf_state", 32'(sif.state), 32'd0);
`ifdef MULTICYCLE_PERF_EN
    check("perf_instret", sif.instret_cnt, 32'd3);
    check("perf_cycles", sif.cycle_cnt, 32'd12);
`endif
    sif.opcode = 7'b0100011;
    @(negedge clk);
    @(negedge clk);
    #1 check("st_memadr_imm", 32'(sif.imm_src), 32'd1);
    sif.mem_ready = 1'b0;
    @(negedge clk);
    #1 check("st_memwrite_state", 32'(sif.state), 32'd5);
    check("st_memwrite_en", enables(), 32'b00010);
    check("st_adr_src", 32'(sif.adr_src), 32'd1);
    reset = 1'b0;
    #1 check("st_rst_mem_write", 32'(sif.mem_write), 32'd0);
    check("st_rst_state", 32'(sif.state), 32'd0);
`ifdef MULTICYCLE_PERF_EN
    check("st_rst_cycles", sif.cycle_cnt, 32'd0);
    check("st_rst_instret", sif.instret_cnt, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
